// File: rtl/cpu_pkg.sv
// Shared CPU definitions: access widths, LSU FSM states and bus widths.
// Includes the alignment legality rule used by the load/store unit.
package cpu_pkg;

   localparam int WB_DW = 32;
   localparam int WB_AW = 32;

   localparam logic [1:0] W_BYTE = 2'b00;
   localparam logic [1:0] W_HALF = 2'b01;
   localparam logic [1:0] W_WORD = 2'b10;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_REQ  = 2'b01,
      S_WAIT = 2'b10,
      S_DONE = 2'b11
   } lsu_state_t;

   function automatic logic req_legal(
      input logic [1:0] width,
      input logic [1:0] offset
   );
      logic ok;
      ok = 1'b0;
      unique case (1'b1)
         (width == W_BYTE): ok = 1'b1;
         (width == W_HALF): ok = ~offset[0];
         (width == W_WORD): ok = (offset == 2'b00);
         default:           ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering: write strobes, store replication and
// load lane extraction with zero/sign extension.
module lsu_lane_align
   import cpu_pkg::*;
(
   input  logic [1:0]       width,
   input  logic             sign_ext,
   input  logic [1:0]       offset,
   input  logic [WB_DW-1:0] store_data,
   input  logic [WB_DW-1:0] bus_data,
   output logic [3:0]       sel,
   output logic [WB_DW-1:0] lane_data,
   output logic [WB_DW-1:0] load_data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v    = bus_data[{offset, 3'b000} +: 8];
      half_v    = bus_data[{offset[1], 4'b0000} +: 16];
      sel       = 4'b0000;
      lane_data = store_data;
      load_data = '0;
      unique case (width)
         W_BYTE: begin
            sel       = 4'b0001 << offset;
            lane_data = {4{store_data[7:0]}};
            load_data = {{24{sign_ext & byte_v[7]}}, byte_v};
         end
         W_HALF: begin
            sel       = 4'b0011 << offset;
            lane_data = {2{store_data[15:0]}};
            load_data = {{16{sign_ext & half_v[15]}}, half_v};
         end
         W_WORD: begin
            sel       = 4'b1111;
            load_data = bus_data;
         end
         default: begin
            sel       = 4'b0000;
            load_data = '0;
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit with a pipelined Wishbone master port.
// Define LSU_TIMEOUT_EN to enable the bus watchdog (TIMEOUT_CYCLES).
module load_store_unit
   import cpu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_enable,
   input  logic             i_we,
   input  logic [1:0]       i_width,
   input  logic             i_signed,
   input  logic [WB_AW-1:0] i_addr,
   input  logic [WB_DW-1:0] i_data,
   input  logic [3:0]       i_reg_idx,
   output logic             o_busy,
   output logic             o_completed,
   output logic             o_error,
   output logic [WB_DW-1:0] o_data,
   output logic [3:0]       o_reg_idx,
   output logic [WB_AW-1:0] o_wb_addr,
   output logic [WB_DW-1:0] o_wb_data,
   output logic [3:0]       o_wb_sel,
   output logic             o_wb_we,
   output logic             o_wb_cyc,
   output logic             o_wb_stb,
   input  logic             i_wb_ack,
   input  logic             i_wb_stall,
   input  logic             i_wb_err,
   input  logic [WB_DW-1:0] i_wb_data
);

   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
      $error("TIMEOUT_CYCLES must be in 1..65535");
   end

   lsu_state_t state;

   logic       we_q;
   logic [1:0] width_q;
   logic       signed_q;
   logic [1:0] off_q;
   logic       pend;
   logic       pend_err;
   logic       timeout;

   logic [1:0]       a_width;
   logic             a_signed;
   logic [1:0]       a_off;
   logic [3:0]       sel;
   logic [WB_DW-1:0] lane_data;
   logic [WB_DW-1:0] load_data;

   // Idle: steer the incoming request; busy: decode the captured one.
   assign a_width  = (state == S_IDLE) ? i_width     : width_q;
   assign a_signed = (state == S_IDLE) ? i_signed    : signed_q;
   assign a_off    = (state == S_IDLE) ? i_addr[1:0] : off_q;

   lsu_lane_align u_align (
      .width      (a_width),
      .sign_ext   (a_signed),
      .offset     (a_off),
      .store_data (i_data),
      .bus_data   (i_wb_data),
      .sel        (sel),
      .lane_data  (lane_data),
      .load_data  (load_data)
   );

`ifdef LSU_TIMEOUT_EN
   localparam logic [15:0] TLIM = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0] tcnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tcnt <= '0;
      end else if (state == S_IDLE) begin
         tcnt <= '0;
      end else if (tcnt != TLIM) begin
         tcnt <= tcnt + 16'd1;
      end
   end

   assign timeout = (state == S_REQ || state == S_WAIT) && (tcnt == TLIM);
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         we_q        <= 1'b0;
         width_q     <= W_BYTE;
         signed_q    <= 1'b0;
         off_q       <= 2'b00;
         pend        <= 1'b0;
         pend_err    <= 1'b0;
         o_busy      <= 1'b0;
         o_completed <= 1'b0;
         o_error     <= 1'b0;
         o_data      <= '0;
         o_reg_idx   <= '0;
         o_wb_addr   <= '0;
         o_wb_data   <= '0;
         o_wb_sel    <= '0;
         o_wb_we     <= 1'b0;
         o_wb_cyc    <= 1'b0;
         o_wb_stb    <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               o_completed <= 1'b0;
               o_error     <= 1'b0;
               pend        <= 1'b0;
               if (i_enable) begin
                  we_q      <= i_we;
                  width_q   <= i_width;
                  signed_q  <= i_signed;
                  off_q     <= i_addr[1:0];
                  o_reg_idx <= i_reg_idx;
                  o_busy    <= 1'b1;
                  if (req_legal(i_width, i_addr[1:0])) begin
                     state     <= S_REQ;
                     o_wb_cyc  <= 1'b1;
                     o_wb_stb  <= 1'b1;
                     o_wb_addr <= {i_addr[WB_AW-1:2], 2'b00};
                     o_wb_data <= lane_data;
                     o_wb_sel  <= sel;
                     o_wb_we   <= i_we;
                  end else begin
                     state       <= S_DONE;
                     o_completed <= 1'b1;
                     o_error     <= 1'b1;
                     o_data      <= '0;
                  end
               end
            end
            S_REQ: begin
               if (!i_wb_stall && (i_wb_ack || i_wb_err)) begin
                  // Response in the accepting cycle: finish via WAIT.
                  state    <= S_WAIT;
                  o_wb_stb <= 1'b0;
                  pend     <= 1'b1;
                  pend_err <= i_wb_err;
                  o_data   <= (i_wb_err || we_q) ? '0 : load_data;
               end else if (timeout) begin
                  state       <= S_DONE;
                  o_wb_cyc    <= 1'b0;
                  o_wb_stb    <= 1'b0;
                  o_completed <= 1'b1;
                  o_error     <= 1'b1;
                  o_data      <= '0;
               end else if (!i_wb_stall) begin
                  state    <= S_WAIT;
                  o_wb_stb <= 1'b0;
               end
            end
            S_WAIT: begin
               if (pend) begin
                  state       <= S_DONE;
                  o_wb_cyc    <= 1'b0;
                  o_completed <= 1'b1;
                  o_error     <= pend_err;
               end else if (i_wb_ack || i_wb_err) begin
                  state       <= S_DONE;
                  o_wb_cyc    <= 1'b0;
                  o_completed <= 1'b1;
                  o_error     <= i_wb_err;
                  o_data      <= (i_wb_err || we_q) ? '0 : load_data;
               end else if (timeout) begin
                  state       <= S_DONE;
                  o_wb_cyc    <= 1'b0;
                  o_completed <= 1'b1;
                  o_error     <= 1'b1;
                  o_data      <= '0;
               end
            end
            S_DONE: begin
               state       <= S_IDLE;
               o_busy      <= 1'b0;
               o_completed <= 1'b0;
               o_error     <= 1'b0;
               pend        <= 1'b0;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: vector table, random
// transactions against a reference model, and reset/timeout sequences.
module tb_load_store_unit;
   import cpu_pkg::*;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_enable, i_we, i_signed;
   logic [1:0]  i_width;
   logic [31:0] i_addr, i_data;
   logic [3:0]  i_reg_idx;
   logic        o_busy, o_completed, o_error;
   logic [31:0] o_data;
   logic [3:0]  o_reg_idx;
   logic [31:0] o_wb_addr, o_wb_data;
   logic [3:0]  o_wb_sel;
   logic        o_wb_we, o_wb_cyc, o_wb_stb;
   logic        i_wb_ack, i_wb_stall, i_wb_err;
   logic [31:0] i_wb_data;

   always #5 clk = ~clk;

   load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset),
      .i_enable(i_enable), .i_we(i_we), .i_width(i_width),
      .i_signed(i_signed), .i_addr(i_addr), .i_data(i_data),
      .i_reg_idx(i_reg_idx),
      .o_busy(o_busy), .o_completed(o_completed), .o_error(o_error),
      .o_data(o_data), .o_reg_idx(o_reg_idx),
      .o_wb_addr(o_wb_addr), .o_wb_data(o_wb_data), .o_wb_sel(o_wb_sel),
      .o_wb_we(o_wb_we), .o_wb_cyc(o_wb_cyc), .o_wb_stb(o_wb_stb),
      .i_wb_ack(i_wb_ack), .i_wb_stall(i_wb_stall), .i_wb_err(i_wb_err),
      .i_wb_data(i_wb_data)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   typedef struct {
      logic        we;
      logic [1:0]  w;
      logic        sg;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  idx;
      int          stall;
      int          ackd;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   function automatic vec_t mk(input logic we, input logic [1:0] w,
      input logic sg, input logic [31:0] addr, input logic [31:0] data,
      input logic [3:0] idx, input int stall, input int ackd,
      input logic err, input logic [31:0] rdata);
      vec_t v;
      v.we = we; v.w = w; v.sg = sg; v.addr = addr; v.data = data;
      v.idx = idx; v.stall = stall; v.ackd = ackd; v.err = err;
      v.rdata = rdata;
      return v;
   endfunction

   // Reference model, straight from the access rules.
   function automatic bit m_legal(input vec_t v);
      if (v.w == 2'd0) return 1;
      if (v.w == 2'd1) return (v.addr % 2) == 0;
      if (v.w == 2'd2) return (v.addr % 4) == 0;
      return 0;
   endfunction

   function automatic logic [31:0] m_load(input vec_t v);
      int unsigned off = v.addr % 4;
      logic [31:0] sh = v.rdata >> (8 * off);
      logic [31:0] x;
      if (v.w == 2'd2) return v.rdata;
      if (v.w == 2'd0) begin
         x = sh & 32'hff;
         if (v.sg && x >= 32'h80) x = x | 32'hffffff00;
      end else begin
         x = sh & 32'hffff;
         if (v.sg && x >= 32'h8000) x = x | 32'hffff0000;
      end
      return x;
   endfunction

   function automatic logic [3:0] m_sel(input vec_t v);
      int unsigned off = v.addr % 4;
      if (v.w == 2'd0) return 4'(1 << off);
      if (v.w == 2'd1) return 4'(3 << off);
      return 4'hf;
   endfunction

   function automatic logic [31:0] m_wdata(input vec_t v);
      if (v.w == 2'd0) return (v.data & 32'hff) * 32'h01010101;
      if (v.w == 2'd1) return (v.data & 32'hffff) * 32'h00010001;
      return v.data;
   endfunction

   task automatic idle_inputs();
      i_enable = 0; i_we = 0; i_width = 0; i_signed = 0;
      i_addr = 0; i_data = 0; i_reg_idx = 0;
      i_wb_ack = 0; i_wb_stall = 0; i_wb_err = 0; i_wb_data = 0;
   endtask

   task automatic run(input vec_t v, input string tag);
      int stb_n = 0, lat = 0, comps = 0, ack_at = -1, exp_lat;
      bit acked = 0, unstable = 0, busy_bad = 0;
      logic busy_after = 1'b1;
      logic [31:0] s_addr = 0, s_wd = 0, c_data = 0;
      logic [3:0] s_sel = 0, c_idx = 0;
      logic s_we = 0, c_err = 0;
      bit legal = m_legal(v);
      @(negedge clk);
      i_enable = 1; i_we = v.we; i_width = v.w; i_signed = v.sg;
      i_addr = v.addr; i_data = v.data; i_reg_idx = v.idx;
      for (int c = 1; c <= 300; c++) begin
         @(negedge clk);
         i_enable = 0; i_we = 1'($urandom); i_width = 2'($urandom);
         i_addr = $urandom; i_data = $urandom; i_reg_idx = 4'($urandom);
         i_wb_ack = 0; i_wb_err = 0; i_wb_stall = 0;
         i_wb_data = $urandom;
         if (o_completed) begin
            comps++;
            if (comps == 1) begin
               lat = c; c_err = o_error; c_data = o_data; c_idx = o_reg_idx;
            end
         end
         if (lat == 0 && !o_busy) busy_bad = 1;
         if (lat != 0 && c == lat + 1) busy_after = o_busy;
         if (o_wb_cyc && o_wb_stb) begin
            if (stb_n == 0) begin
               s_addr = o_wb_addr; s_wd = o_wb_data;
               s_sel = o_wb_sel; s_we = o_wb_we;
            end else if (s_addr !== o_wb_addr || s_wd !== o_wb_data ||
                         s_sel !== o_wb_sel || s_we !== o_wb_we) begin
               unstable = 1;
            end
            stb_n++;
            i_wb_stall = (stb_n <= v.stall);
            if (!i_wb_stall) ack_at = c + v.ackd;
         end
         if (c == ack_at && !acked) begin
            acked = 1;
            if (v.err) i_wb_err = 1;
            else i_wb_ack = 1;
            i_wb_data = v.rdata;
         end
         if (lat != 0 && c == lat + 2) break;
      end
      exp_lat = legal ? v.stall + 2 + ((v.ackd == 0) ? 1 : v.ackd) : 1;
      chk({tag, " latency"}, lat, exp_lat);
      chk({tag, " pulses"}, comps, 1);
      chk({tag, " error"}, {31'b0, c_err}, {31'b0, (!legal || v.err)});
      chk({tag, " reg_idx"}, {28'b0, c_idx}, {28'b0, v.idx});
      chk({tag, " busy"}, {31'b0, busy_bad}, 0);
      chk({tag, " busy_after"}, {31'b0, busy_after}, 0);
      chk({tag, " stb_cycles"}, stb_n, legal ? v.stall + 1 : 0);
      if (!legal || v.err) chk({tag, " data0"}, c_data, 0);
      else if (!v.we) chk({tag, " load"}, c_data, m_load(v));
      if (legal) begin
         chk({tag, " addr"}, s_addr, v.addr & 32'hfffffffc);
         chk({tag, " sel"}, {28'b0, s_sel}, {28'b0, m_sel(v)});
         chk({tag, " we"}, {31'b0, s_we}, {31'b0, v.we});
         chk({tag, " stable"}, {31'b0, unstable}, 0);
         if (v.we) chk({tag, " wdata"}, s_wd, m_wdata(v));
      end
   endtask

   vec_t tbl[12];

   initial begin
      int cyc_n, comps;
      logic c_err;
      logic [31:0] c_data;
      vec_t v;

      tbl[0]  = mk(0, W_WORD, 0, 32'hb0000010, 0, 4'h3, 0, 1, 0, 32'hdeadbeef);
      tbl[1]  = mk(0, W_BYTE, 1, 32'hb0000003, 0, 4'h5, 0, 1, 0, 32'h80000000);
      tbl[2]  = mk(0, W_BYTE, 0, 32'hb0000003, 0, 4'h6, 0, 1, 0, 32'h80000000);
      tbl[3]  = mk(1, W_HALF, 0, 32'hb0000002, 32'h1234abcd, 4'h1, 3, 0, 0, 0);
      tbl[4]  = mk(0, W_WORD, 0, 32'hb0000001, 0, 4'h7, 0, 1, 0, 32'h1);
      tbl[5]  = mk(0, W_HALF, 1, 32'hb0000005, 0, 4'h8, 0, 1, 0, 32'h2);
      tbl[6]  = mk(1, 2'b11, 0, 32'hb0000008, 32'h55, 4'ha, 0, 1, 0, 0);
      tbl[7]  = mk(0, W_WORD, 0, 32'hb0000020, 0, 4'hb, 1, 1, 1, 32'hffffffff);
      tbl[8]  = mk(0, W_HALF, 1, 32'hb0000006, 0, 4'h9, 1, 0, 0, 32'h80010000);
      tbl[9]  = mk(1, W_BYTE, 0, 32'hb0000021, 32'h000000a5, 4'hc, 0, 2, 0, 0);
      tbl[10] = mk(0, W_HALF, 0, 32'hb0000040, 0, 4'hd, 0, 3, 0, 32'h1234fedc);
      tbl[11] = mk(1, W_WORD, 0, 32'hb0000044, 32'hcafef00d, 4'he, 2, 1, 0, 0);

      idle_inputs();
      reset = 0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst busy", {31'b0, o_busy}, 0);
      chk("rst completed", {31'b0, o_completed}, 0);
      chk("rst error", {31'b0, o_error}, 0);
      chk("rst data", o_data, 0);
      chk("rst reg_idx", {28'b0, o_reg_idx}, 0);
      chk("rst wb_addr", o_wb_addr, 0);
      chk("rst wb_data", o_wb_data, 0);
      chk("rst wb_sel", {28'b0, o_wb_sel}, 0);
      chk("rst wb_we", {31'b0, o_wb_we}, 0);
      chk("rst wb_cyc", {31'b0, o_wb_cyc}, 0);
      chk("rst wb_stb", {31'b0, o_wb_stb}, 0);
      @(negedge clk);
      reset = 1;

      for (int i = 0; i < 12; i++) run(tbl[i], $sformatf("vec%0d", i));

      for (int i = 0; i < 60; i++) begin
         v.we = 1'($urandom);
         v.w = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
         v.sg = 1'($urandom);
         v.addr = 32'hb0000000 | $urandom_range(0, 255);
         v.data = $urandom;
         v.idx = 4'($urandom);
         v.stall = $urandom_range(0, 3);
         v.ackd = $urandom_range(0, 3 - v.stall);
         v.err = ($urandom_range(0, 7) == 0);
         v.rdata = $urandom;
         run(v, $sformatf("rnd%0d", i));
      end

      // Enable while busy must be ignored.
      @(negedge clk);
      i_enable = 1; i_we = 0; i_width = W_WORD; i_addr = 32'hb0000001;
      i_reg_idx = 4'h2;
      @(negedge clk);
      chk("busy_ign done", {30'b0, o_completed, o_error}, 32'h3);
      i_enable = 1; i_addr = 32'hb0000010;
      @(negedge clk);
      i_enable = 0;
      cyc_n = 0; comps = 0;
      for (int c = 0; c < 6; c++) begin
         if (o_wb_cyc) cyc_n++;
         if (o_completed) comps++;
         @(negedge clk);
      end
      chk("busy_ign cyc", cyc_n, 0);
      chk("busy_ign comps", comps, 0);

      // Reset during WAIT abandons the transaction.
      i_enable = 1; i_we = 0; i_width = W_WORD; i_addr = 32'hb0000010;
      @(negedge clk);
      i_enable = 0;
      @(negedge clk);
      chk("rstwait in_wait", {30'b0, o_wb_cyc, o_wb_stb}, 32'h2);
      reset = 0;
      #1;
      chk("rstwait cyc", {31'b0, o_wb_cyc}, 0);
      chk("rstwait stb", {31'b0, o_wb_stb}, 0);
      chk("rstwait busy", {31'b0, o_busy}, 0);
      @(negedge clk);
      reset = 1;
      i_wb_ack = 1; i_wb_data = 32'h12345678;
      comps = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         i_wb_ack = 0;
         if (o_completed || o_busy || o_wb_cyc) comps++;
      end
      chk("rstwait late_ack", comps, 0);

      // No response at all: watchdog or indefinite wait.
      i_enable = 1; i_we = 0; i_width = W_WORD; i_addr = 32'hb0000030;
      cyc_n = 0; comps = 0; c_err = 0; c_data = 32'hffffffff;
      for (int c = 0; c < 110; c++) begin
         @(negedge clk);
         i_enable = 0;
         if (o_wb_cyc) cyc_n++;
         if (o_completed) begin
            comps++; c_err = o_error; c_data = o_data;
         end
      end
`ifdef LSU_TIMEOUT_EN
      chk("timeout cyc_cycles", cyc_n, TO);
      chk("timeout comps", comps, 1);
      chk("timeout error", {31'b0, c_err}, 1);
      chk("timeout data", c_data, 0);
`else
      chk("nowdog cyc_cycles", cyc_n, 110);
      chk("nowdog comps", comps, 0);
      chk("nowdog busy", {31'b0, o_busy}, 1);
`endif
      reset = 0;
      @(negedge clk);
      reset = 1;
      @(negedge clk);
      chk("recover cyc", {31'b0, o_wb_cyc}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, bus-watchdog limit in cycles (range 1..65535).
REQ-002 Port: clk  input  1  single clock, all state on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: i_enable  input  1  one-cycle request strobe from the execute stage.
REQ-005 Port: i_we  input  1  1=store, 0=load.
REQ-006 Port: i_width  input  2  00 byte, 01 half, 10 word, 11 reserved.
REQ-007 Port: i_signed  input  1  sign-extend loaded byte/half.
REQ-008 Port: i_addr  input  32  byte address.
REQ-009 Port: i_data  input  32  store data, LSB-aligned.
REQ-010 Port: i_reg_idx  input  4  load destination register index, returned with result.
REQ-011 Port: o_busy  output  1  request in flight.
REQ-012 Port: o_completed  output  1  one-cycle completion pulse.
REQ-013 Port: o_error  output  1  valid with o_completed; misalign, reserved width, bus error or timeout.
REQ-014 Port: o_data  output  32  extended load result, valid with o_completed.
REQ-015 Port: o_reg_idx  output  4  captured i_reg_idx, valid with o_completed.
REQ-016 Ports: o_wb_addr out 32, o_wb_data out 32, o_wb_sel out 4, o_wb_we out 1, o_wb_cyc out 1, o_wb_stb out 1, i_wb_ack in 1, i_wb_stall in 1, i_wb_err in 1, i_wb_data in 32; pipelined Wishbone master.

Function
REQ-017 FSM states IDLE, REQ, WAIT, DONE; IDLE->REQ on i_enable with legal request; REQ->WAIT when stb accepted (i_wb_stall low); WAIT->DONE on ack/err; DONE->IDLE unconditionally.
REQ-018 Request inputs are captured on the i_enable edge; i_enable while o_busy is high is ignored.
REQ-019 In REQ: cyc=1, stb=1; stb held with stable addr/data/sel/we until sampled with i_wb_stall low.
REQ-020 In WAIT: cyc=1, stb=0; ack or err sampled during REQ's accepting cycle is also honoured.
REQ-021 o_completed pulses exactly one cycle, in DONE, the cycle after ack/err is sampled; minimum latency enable->completed is 3 cycles.
REQ-022 o_wb_addr = {addr[31:2],2'b00}; sel = 0001<<addr[1:0] (byte), 0011<<addr[1:0] (half), 1111 (word).
REQ-023 Store data: byte replicated to all four lanes, half replicated to both halves, word unchanged.
REQ-024 Load data: lane selected by addr[1:0], zero- or sign-extended to 32 bits per i_signed; word unchanged.
REQ-025 Half with addr[0]=1, word with addr[1:0]!=0, or i_width=11: no bus cycle; DONE entered next cycle with o_error=1, o_data=0.
REQ-026 i_wb_err: cyc dropped, o_completed with o_error=1, o_data=0.
REQ-027 o_busy high in REQ, WAIT, DONE; low only in IDLE.

Reset
REQ-028 reset low asynchronously forces IDLE and o_wb_cyc, o_wb_stb, o_busy, o_completed, o_error, o_wb_we=0, o_data, o_wb_addr, o_wb_data=0, o_wb_sel=0, o_reg_idx=0.
REQ-029 Reset mid-transaction abandons it with no completion pulse; ack arriving after reset is ignored.

Configuration
REQ-030 Macro LSU_TIMEOUT_EN defined: counter starts on REQ entry; if no ack/err within TIMEOUT_CYCLES cycles, cyc/stb drop and DONE asserts o_error=1, o_data=0.
REQ-031 Macro LSU_TIMEOUT_EN undefined: no counter; unit waits indefinitely; TIMEOUT_CYCLES ignored.

Structure
REQ-032 Shared package cpu_pkg holds width encodings (W_BYTE, W_HALF, W_WORD), FSM state encodings, and the Wishbone data/addr width constants.
REQ-033 One combinational sub-module lsu_lane_align produces sel, store-lane data and extended load data.

Verification
REQ-034 Word load addr 0xb0000010, ack 1 cycle after stb, i_wb_data 0xdeadbeef -> o_data 0xdeadbeef, o_error 0, completed 3 cycles after enable.
REQ-035 Signed byte load addr 0xb0000003, i_wb_data 0x80000000 -> sel 1000, o_data 0xffffff80; unsigned -> 0x00000080.
REQ-036 Half store addr 0xb0000002, i_data 0x1234abcd, stall high 3 cycles -> stb held 4 cycles, sel 1100, o_wb_data 0xabcdabcd, we 1.
REQ-037 Word load addr 0xb0000001 -> no cyc, o_completed+o_error next cycle; second enable while busy ignored.
REQ-038 With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> cyc drops, o_error 1; without macro, cyc stays high 100 cycles.
REQ-039 reset low during WAIT -> cyc/stb low immediately, no o_completed; later ack ignored.
